// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the program counter, drives the
// instruction-memory address, captures each returned byte and offers it
// to the decoder over a valid/ready handshake. It also handles decoder
// jumps, stops on the halt opcode and restarts on start.
module fetch_controller #(
  parameter logic [7:0] START_ADDR  = 8'd10,
  parameter logic [7:0] HALT_OPCODE = 8'hE0,
  parameter int         ADDR_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] endereco,
  input  logic [7:0]            instrucao_mem,
  output logic [7:0]            instrucao,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  salto,
  input  logic [ADDR_WIDTH-1:0] destino,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [7:0]            r_instr;
  logic                  r_valid;
  logic                  r_halted;
  logic                  r_busy;

  logic                  w_handshake;
  logic                  w_jump;
  logic                  w_load;
  logic                  w_is_halt;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Handshake, jump and load qualifiers derived from the current state.
  // A completed jump takes precedence over the sequential load so the
  // byte already fetched from endereco (the fall-through successor) is dropped.
  always_comb begin
    w_handshake = r_valid && instr_ready;
    w_jump      = (r_state == S_RUN) && salto && w_handshake;
    w_load      = (r_state == S_RUN) && (!r_valid || instr_ready) && !w_jump;
    w_is_halt   = (instrucao_mem == HALT_OPCODE);
    w_next_addr = r_addr + 1'b1;
  end

  // Single FSM: state, address, presented instruction and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= START_ADDR;
      r_pc     <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= START_ADDR;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end

        S_RUN: begin
          if (w_jump) begin
            // Redirect; the memory returns MEMI[destino] before the next edge.
            r_addr  <= destino;
            r_valid <= 1'b0;
          end else if (w_load) begin
            r_instr <= instrucao_mem;
            r_pc    <= r_addr;
            r_valid <= 1'b1;
            if (w_is_halt) begin
              // Keep the address on the halt byte; nothing past it is fetched.
              r_state <= S_DRAIN;
            end else begin
              r_addr <= w_next_addr;
            end
          end
          // Otherwise: backpressure, every register holds.
        end

        S_DRAIN: begin
          if (instr_ready) begin
            r_valid  <= 1'b0;
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
          end
        end

        S_HALTED: begin
          if (start) begin
            r_addr   <= START_ADDR;
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign endereco    = r_addr;
  assign instrucao   = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: falling-edge instruction memory model,
// directed sequence followed by randomized traffic, and a scoreboard of
// expected presented instructions that a negedge monitor pops and checks.
module tb_fetch_controller;

  localparam logic [7:0] START = 8'd10;
  localparam logic [7:0] HALT  = 8'hE0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] endereco;
  logic [7:0] instrucao_mem = 8'h00;
  logic [7:0] instrucao;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       salto = 1'b0;
  logic [7:0] destino = 8'h00;
  logic [7:0] pc;
  logic       halted;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [256];

  fetch_controller #(
    .START_ADDR (START),
    .HALT_OPCODE(HALT),
    .ADDR_WIDTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .endereco     (endereco),
    .instrucao_mem(instrucao_mem),
    .instrucao    (instrucao),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .salto        (salto),
    .destino      (destino),
    .pc           (pc),
    .halted       (halted),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Instruction memory: synchronous read on the falling edge.
  always @(negedge clock) instrucao_mem <= mem[endereco];

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (v == HALT) v = 8'h3C;
      mem[i] = v;
    end
    mem[10]  = 8'h08;
    mem[11]  = 8'h10;
    mem[12]  = 8'h17;
    mem[13]  = 8'h17;
    mem[60]  = 8'h11;
    mem[64]  = 8'hA4;
    mem[65]  = HALT;
    mem[130] = HALT;
    mem[255] = 8'h01;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  // Model view: the program is either running or not; while running the
  // decoder sees an uninterrupted stream of (pc, MEMI[pc]) except for a
  // single empty cycle after start or after an accepted jump.
  logic [7:0] exp_q [$];
  bit         m_run = 0;
  bit         m_halt = 0;
  bit         m_bubble = 0;
  bit         just_rst = 0;
  logic [7:0] m_bub_addr = 8'h00;
  logic [7:0] m_end = 8'h00;

  always @(negedge clock) begin
    logic [7:0] e;
    logic [7:0] nxt;
    if (reset) begin
      exp_q.delete();
      m_run    = 0;
      m_halt   = 0;
      m_bubble = 0;
      just_rst = 1;
    end else begin
      if (just_rst) begin
        chk("reset_endereco", int'(endereco), int'(START));
        chk("reset_pc", int'(pc), 0);
        chk("reset_instrucao", int'(instrucao), 0);
        just_rst = 0;
      end
      if (!m_run) begin
        chk("idle_valid", int'(instr_valid), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_halted", int'(halted), int'(m_halt));
        if (m_halt) chk("halted_endereco", int'(endereco), int'(m_end));
        if (start) begin
          m_run      = 1;
          m_halt     = 0;
          m_bubble   = 1;
          m_bub_addr = START;
          exp_q.push_back(START);
        end
      end else begin
        chk("run_busy", int'(busy), 1);
        chk("run_halted", int'(halted), 0);
        if (m_bubble) begin
          chk("bubble_valid", int'(instr_valid), 0);
          chk("bubble_endereco", int'(endereco), int'(m_bub_addr));
          m_bubble = 0;
        end else begin
          chk("run_valid", int'(instr_valid), 1);
          if (instr_valid) begin
            if (exp_q.size() == 0) begin
              chk("scoreboard_nonempty", 0, 1);
            end else begin
              e = exp_q[0];
              nxt = e + 8'd1;
              chk("pc", int'(pc), int'(e));
              chk("instrucao", int'(instrucao), int'(mem[e]));
              chk("next_endereco", int'(endereco), (mem[e] == HALT) ? int'(e) : int'(nxt));
              if (instr_ready) begin
                void'(exp_q.pop_front());
                if (mem[e] == HALT) begin
                  m_run  = 0;
                  m_halt = 1;
                  m_end  = e;
                end else if (salto) begin
                  m_bubble   = 1;
                  m_bub_addr = destino;
                  exp_q.push_back(destino);
                end else begin
                  exp_q.push_back(nxt);
                end
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pc(input logic [7:0] a);
    int n;
    n = 0;
    while (!(instr_valid && pc == a) && n < 60) begin
      instr_ready = 1'b1;
      step();
      n++;
    end
    chk("wait_pc_reached", int'(pc), int'(a));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Start and stream the first instructions.
    start = 1'b1;
    step();
    start = 1'b0;
    instr_ready = 1'b1;

    // Backpressure at pc=12.
    wait_pc(8'd12);
    instr_ready = 1'b0;
    repeat (3) step();
    instr_ready = 1'b1;

    // Jump from pc=13: first refused (no handshake), then accepted.
    wait_pc(8'd13);
    salto = 1'b1;
    destino = 8'd60;
    instr_ready = 1'b0;
    repeat (2) step();
    instr_ready = 1'b1;
    step();
    salto = 1'b0;

    // Jump to 64, run into the halt at 65, stall in drain.
    wait_pc(8'd60);
    salto = 1'b1;
    destino = 8'd64;
    step();
    salto = 1'b0;
    wait_pc(8'd65);
    instr_ready = 1'b0;
    salto = 1'b1;
    destino = 8'd3;
    repeat (2) step();
    salto = 1'b0;
    instr_ready = 1'b1;
    repeat (4) step();

    // Restart, then jump to 255 to exercise address wrap.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pc(8'd10);
    salto = 1'b1;
    destino = 8'd255;
    step();
    salto = 1'b0;
    wait_pc(8'd0);
    repeat (2) step();

    // Reset while an instruction is being presented.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      salto       = ($urandom_range(0, 7) == 0);
      destino     = 8'($urandom);
      start       = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    salto = 1'b0;
    instr_ready = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 8-bit instruction memory, whose read is synchronous on the falling edge.
- Owns the program counter and drives the memory address.
- Captures each returned instruction and presents it to the decoder over a valid/ready handshake.
- Handles jumps requested by the decoder, stops fetching on the halt opcode, and restarts on command.

Parameters:
START_ADDR, 8'd10, address of the first instruction fetched after start.
HALT_OPCODE, 8'hE0, instruction value that ends the program.
ADDR_WIDTH, 8, width of the address and program counter (fixed at 8 for this memory).

Ports:
clock  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin or restart execution at START_ADDR (IDLE/HALTED only).
endereco  output  8  registered address to instruction memory; the next address to fetch.
instrucao_mem  input  8  instruction-memory data; MEMI[endereco] sampled at the preceding falling edge.
instrucao  output  8  instruction presented to the decoder.
instr_valid  output  1  instrucao/pc hold a valid instruction.
instr_ready  input  1  decoder accepts instrucao this cycle.
salto  input  1  jump request, qualified by the handshake.
destino  input  8  jump target address.
pc  output  8  address of the instruction currently presented.
halted  output  1  high in HALTED.
busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset values, applied at the rising edge with reset=1 in any state:
  - state=IDLE, endereco=START_ADDR, instrucao=0, pc=0.
  - instr_valid=0, halted=0, busy=0.
  - reset has priority over every other input.
- Memory timing:
  - endereco changes at rising edge k; memory reads at the next falling edge.
  - instrucao_mem is valid at rising edge k+1.
  - No wait state is needed after any address change.
- Load condition: load = (state==RUN) && (!instr_valid || instr_ready) && !(salto && instr_valid && instr_ready).
- On load:
  - instrucao<=instrucao_mem, pc<=endereco, instr_valid<=1.
  - If instrucao_mem != HALT_OPCODE: endereco<=endereco+1, modulo 256 (255 wraps to 0).
  - If instrucao_mem == HALT_OPCODE: endereco unchanged, state->DRAIN.
- In RUN with instr_valid=1 and instr_ready=0 (backpressure): all registers hold; no fetch is lost or skipped.
- Jump:
  - Accepted only in RUN, when salto && instr_valid && instr_ready.
  - Action: endereco<=destino, instr_valid<=0 (flushes the sequential successor), state stays RUN.
  - The instruction at destino is loaded at the next edge, so instr_valid=1 one cycle after the jump.
  - salto is ignored when the handshake does not complete, and in IDLE, DRAIN and HALTED.
- States:
  - IDLE: instr_valid=0. On start: endereco<=START_ADDR, state->RUN. First instruction is valid one cycle after start is sampled.
  - RUN: load/jump rules above. busy=1.
  - DRAIN: the halt instruction is presented. On instr_ready: instr_valid<=0, state->HALTED. busy=1.
  - HALTED: halted=1, instr_valid=0, endereco holds. On start: endereco<=START_ADDR, state->RUN, halted<=0.
- start is ignored in RUN and DRAIN.
- instrucao and pc hold their last values whenever instr_valid=0.

Test Plan:
1. Reset, then start at edge N, instr_ready=1 → after N+1: valid=1, pc=10, instrucao=0x08; after N+2: pc=11, 0x10; after N+3: pc=12, 0x17; busy=1.
2. Backpressure: at pc=12, hold instr_ready=0 for 3 cycles → instrucao=0x17, pc=12, endereco=13 stable. Release → next pc=13 (0x17), no skip or duplicate.
3. Jump: salto=1, destino=60 while pc=13 is accepted → next cycle valid=0; following cycle pc=60, 0x11. pc=14 is never presented. Repeat with instr_ready=0 → salto ignored.
4. Halt: jump to 64 → pc=64 (0xA4), then pc=65 (0xE0). State DRAIN, endereco stays 65. Hold ready low 2 cycles, then accept → valid=0, halted=1, busy=0. Later start → pc=10, 0x08, halted=0.
5. Wrap: jump to 255 (bench memory 0x01 at 255) → pc=255 then pc=0, endereco=1.
6. Reset mid-run with valid=1 → next cycle valid=0, endereco=10, busy=0. No fetch occurs until start.
